// File: rtl/alu_share_arbiter_if.sv
// Bundles both requester channels, the shared-ALU drive and the contention count.
// The slave modport is the arbiter's view; master is the environment's view.
interface alu_share_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3,
    parameter int CNT_W  = 16
);
    logic              req0_valid_i;
    logic              req0_ready_o;
    logic [CTRL_W-1:0] req0_ctrl_i;
    logic [WIDTH-1:0]  req0_data1_i;
    logic [WIDTH-1:0]  req0_data2_i;
    logic              rsp0_valid_o;
    logic              rsp0_ready_i;
    logic [WIDTH-1:0]  rsp0_data_o;

    logic              req1_valid_i;
    logic              req1_ready_o;
    logic [CTRL_W-1:0] req1_ctrl_i;
    logic [WIDTH-1:0]  req1_data1_i;
    logic [WIDTH-1:0]  req1_data2_i;
    logic              rsp1_valid_o;
    logic              rsp1_ready_i;
    logic [WIDTH-1:0]  rsp1_data_o;

    logic [CTRL_W-1:0] alu_ctrl_o;
    logic [WIDTH-1:0]  alu_data1_o;
    logic [WIDTH-1:0]  alu_data2_o;
    logic [WIDTH-1:0]  alu_result_i;

    logic [CNT_W-1:0]  contention_cnt_o;

    modport slave (
        input  req0_valid_i, req0_ctrl_i, req0_data1_i, req0_data2_i, rsp0_ready_i,
        input  req1_valid_i, req1_ctrl_i, req1_data1_i, req1_data2_i, rsp1_ready_i,
        input  alu_result_i,
        output req0_ready_o, rsp0_valid_o, rsp0_data_o,
        output req1_ready_o, rsp1_valid_o, rsp1_data_o,
        output alu_ctrl_o, alu_data1_o, alu_data2_o, contention_cnt_o
    );

    modport master (
        output req0_valid_i, req0_ctrl_i, req0_data1_i, req0_data2_i, rsp0_ready_i,
        output req1_valid_i, req1_ctrl_i, req1_data1_i, req1_data2_i, rsp1_ready_i,
        output alu_result_i,
        input  req0_ready_o, rsp0_valid_o, rsp0_data_o,
        input  req1_ready_o, rsp1_valid_o, rsp1_data_o,
        input  alu_ctrl_o, alu_data1_o, alu_data2_o, contention_cnt_o
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters; result 1 cycle after accept.
// A requester whose one-entry result buffer is full and undrained sees ready low; the other proceeds.
module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    alu_share_arbiter_if.slave  bus
);

    logic              r_rsp0_vld;
    logic              r_rsp1_vld;
    logic [WIDTH-1:0]  r_rsp0_dat;
    logic [WIDTH-1:0]  r_rsp1_dat;
    logic              r_prio;        // 0: R0 wins a tie, 1: R1 wins a tie
    logic [CNT_W-1:0]  r_cnt;

    logic              w_elig0;
    logic              w_elig1;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_contend;
    logic [CTRL_W-1:0] w_alu_ctrl;
    logic [WIDTH-1:0]  w_alu_data1;
    logic [WIDTH-1:0]  w_alu_data2;

    always_comb begin
        w_elig0     = bus.req0_valid_i & (~r_rsp0_vld | bus.rsp0_ready_i);
        w_elig1     = bus.req1_valid_i & (~r_rsp1_vld | bus.rsp1_ready_i);
        // Gate with reset so nothing is accepted while the block is held in reset.
        w_grant0    = rst_i & w_elig0 & (~w_elig1 | ~r_prio);
        w_grant1    = rst_i & w_elig1 & (~w_elig0 |  r_prio);
        w_contend   = bus.req0_valid_i & bus.req1_valid_i & (w_grant0 | w_grant1);
        w_alu_ctrl  = '0;
        w_alu_data1 = '0;
        w_alu_data2 = '0;
        if (w_grant0) begin
            w_alu_ctrl  = bus.req0_ctrl_i;
            w_alu_data1 = bus.req0_data1_i;
            w_alu_data2 = bus.req0_data2_i;
        end else if (w_grant1) begin
            w_alu_ctrl  = bus.req1_ctrl_i;
            w_alu_data1 = bus.req1_data1_i;
            w_alu_data2 = bus.req1_data2_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rsp0_vld <= 1'b0;
            r_rsp1_vld <= 1'b0;
            r_rsp0_dat <= '0;
            r_rsp1_dat <= '0;
            r_prio     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            // A new grant overrides a same-cycle drain so valid never bubbles.
            if (w_grant0) begin
                r_rsp0_dat <= bus.alu_result_i;
                r_rsp0_vld <= 1'b1;
            end else if (bus.rsp0_ready_i) begin
                r_rsp0_vld <= 1'b0;
            end
            if (w_grant1) begin
                r_rsp1_dat <= bus.alu_result_i;
                r_rsp1_vld <= 1'b1;
            end else if (bus.rsp1_ready_i) begin
                r_rsp1_vld <= 1'b0;
            end
            if (w_grant0) begin
                r_prio <= 1'b1;
            end else if (w_grant1) begin
                r_prio <= 1'b0;
            end
            if (w_contend && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.req0_ready_o     = w_grant0;
    assign bus.req1_ready_o     = w_grant1;
    assign bus.rsp0_valid_o     = r_rsp0_vld;
    assign bus.rsp1_valid_o     = r_rsp1_vld;
    assign bus.rsp0_data_o      = r_rsp0_dat;
    assign bus.rsp1_data_o      = r_rsp1_dat;
    assign bus.alu_ctrl_o       = w_alu_ctrl;
    assign bus.alu_data1_o      = w_alu_data1;
    assign bus.alu_data2_o      = w_alu_data2;
    assign bus.contention_cnt_o = r_cnt;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on the shared port.
module tb_alu_share_arbiter;

    logic clk_i = 1'b0;
    logic rst_i;
    int   checks   = 0;
    int   failures = 0;

    alu_share_arbiter_if #(.WIDTH(32), .CTRL_W(3), .CNT_W(16)) bus ();

    alu_share_arbiter #(.WIDTH(32), .CTRL_W(3), .CNT_W(16)) u_dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        case (bus.alu_ctrl_o)
            3'b000:  bus.alu_result_i = bus.alu_data1_o & bus.alu_data2_o;
            3'b001:  bus.alu_result_i = bus.alu_data1_o ^ bus.alu_data2_o;
            3'b010:  bus.alu_result_i = bus.alu_data1_o << bus.alu_data2_o[4:0];
            3'b011:  bus.alu_result_i = bus.alu_data1_o + bus.alu_data2_o;
            3'b100:  bus.alu_result_i = bus.alu_data1_o - bus.alu_data2_o;
            3'b101:  bus.alu_result_i = bus.alu_data1_o * bus.alu_data2_o;
            3'b110:  bus.alu_result_i = bus.alu_data1_o + bus.alu_data2_o;
            default: bus.alu_result_i = $unsigned($signed(bus.alu_data1_o) >>> bus.alu_data2_o[4:0]);
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req0(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        bus.req0_valid_i = v;
        bus.req0_ctrl_i  = c;
        bus.req0_data1_i = a;
        bus.req0_data2_i = b;
    endtask

    task automatic set_req1(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        bus.req1_valid_i = v;
        bus.req1_ctrl_i  = c;
        bus.req1_data1_i = a;
        bus.req1_data2_i = b;
    endtask

    initial begin
        logic [31:0] n0;
        logic [31:0] n1;
        rst_i = 1'b0;
        set_req0(1'b1, 3'd3, 32'd1, 32'd1);
        set_req1(1'b0, 3'd0, 32'd0, 32'd0);
        bus.rsp0_ready_i = 1'b1;
        bus.rsp1_ready_i = 1'b1;

        // Held in reset
        #12;
        chk("rst_rsp0_valid", 32'(bus.rsp0_valid_o), 32'd0);
        chk("rst_rsp1_valid", 32'(bus.rsp1_valid_o), 32'd0);
        chk("rst_rsp0_data", bus.rsp0_data_o, 32'd0);
        chk("rst_rsp1_data", bus.rsp1_data_o, 32'd0);
        chk("rst_cnt", 32'(bus.contention_cnt_o), 32'd0);
        chk("rst_no_accept", 32'(bus.req0_ready_o), 32'd0);
        bus.req0_valid_i = 1'b0;
        rst_i = 1'b1;
        tick();

        // Single op: R0 add 5+7
        set_req0(1'b1, 3'd3, 32'd5, 32'd7);
        #1;
        chk("single_ready0", 32'(bus.req0_ready_o), 32'd1);
        chk("single_alu_ctrl", 32'(bus.alu_ctrl_o), 32'd3);
        chk("single_alu_d1", bus.alu_data1_o, 32'd5);
        chk("single_alu_d2", bus.alu_data2_o, 32'd7);
        tick();
        bus.req0_valid_i = 1'b0;
        #1;
        chk("single_rsp0_valid", 32'(bus.rsp0_valid_o), 32'd1);
        chk("single_rsp0_data", bus.rsp0_data_o, 32'd12);
        chk("single_alu_idle_ctrl", 32'(bus.alu_ctrl_o), 32'd0);
        chk("single_alu_idle_d1", bus.alu_data1_o, 32'd0);
        chk("single_alu_idle_d2", bus.alu_data2_o, 32'd0);
        chk("single_cnt", 32'(bus.contention_cnt_o), 32'd0);
        tick();
        chk("single_drained", 32'(bus.rsp0_valid_o), 32'd0);

        // Fresh reset so the pointer starts at R0 again
        rst_i = 1'b0;
        #2;
        rst_i = 1'b1;

        // Dual contention: R0 sub 10-3, R1 mul 6*7
        set_req0(1'b1, 3'd4, 32'd10, 32'd3);
        set_req1(1'b1, 3'd5, 32'd6, 32'd7);
        #1;
        chk("dual_c0_ready0", 32'(bus.req0_ready_o), 32'd1);
        chk("dual_c0_ready1", 32'(bus.req1_ready_o), 32'd0);
        tick();
        bus.req0_valid_i = 1'b0;
        #1;
        chk("dual_rsp0_valid", 32'(bus.rsp0_valid_o), 32'd1);
        chk("dual_rsp0_data", bus.rsp0_data_o, 32'd7);
        chk("dual_c1_ready1", 32'(bus.req1_ready_o), 32'd1);
        chk("dual_cnt_c1", 32'(bus.contention_cnt_o), 32'd1);
        tick();
        bus.req1_valid_i = 1'b0;
        #1;
        chk("dual_rsp1_valid", 32'(bus.rsp1_valid_o), 32'd1);
        chk("dual_rsp1_data", bus.rsp1_data_o, 32'd42);
        chk("dual_rsp0_drained", 32'(bus.rsp0_valid_o), 32'd0);
        chk("dual_cnt", 32'(bus.contention_cnt_o), 32'd1);
        tick();

        // Back-to-back fairness: 8 cycles of continuous dual load
        n0 = 32'd0;
        n1 = 32'd0;
        set_req0(1'b1, 3'd3, n0, 32'd100);
        set_req1(1'b1, 3'd3, n1, 32'd200);
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("rr_ready0", 32'(bus.req0_ready_o), (c % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_ready1", 32'(bus.req1_ready_o), (c % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            if (c % 2 == 0) begin
                chk("rr_rsp0_valid", 32'(bus.rsp0_valid_o), 32'd1);
                chk("rr_rsp0_data", bus.rsp0_data_o, n0 + 32'd100);
                n0 = n0 + 32'd1;
                bus.req0_data1_i = n0;
            end else begin
                chk("rr_rsp1_valid", 32'(bus.rsp1_valid_o), 32'd1);
                chk("rr_rsp1_data", bus.rsp1_data_o, n1 + 32'd200);
                n1 = n1 + 32'd1;
                bus.req1_data1_i = n1;
            end
        end
        chk("rr_grants0", n0, 32'd4);
        chk("rr_grants1", n1, 32'd4);
        chk("rr_cnt", 32'(bus.contention_cnt_o), 32'd9);
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        tick();

        // Backpressure on R1 while R0 keeps flowing
        bus.rsp1_ready_i = 1'b0;
        set_req1(1'b1, 3'd1, 32'h0000_00F0, 32'h0000_00FF);
        #1;
        chk("bp_first_ready1", 32'(bus.req1_ready_o), 32'd1);
        tick();
        set_req1(1'b1, 3'd0, 32'h0000_00FF, 32'h0000_003C);
        set_req0(1'b1, 3'd3, 32'd1, 32'd2);
        #1;
        chk("bp_rsp1_valid", 32'(bus.rsp1_valid_o), 32'd1);
        chk("bp_rsp1_data", bus.rsp1_data_o, 32'h0000_000F);
        chk("bp_ready1_blocked", 32'(bus.req1_ready_o), 32'd0);
        chk("bp_ready0_granted", 32'(bus.req0_ready_o), 32'd1);
        tick();
        bus.req0_valid_i = 1'b0;
        #1;
        chk("bp_rsp0_data", bus.rsp0_data_o, 32'd3);
        chk("bp_cnt", 32'(bus.contention_cnt_o), 32'd10);
        chk("bp_ready1_still_blocked", 32'(bus.req1_ready_o), 32'd0);
        tick();
        chk("bp_rsp1_hold", bus.rsp1_data_o, 32'h0000_000F);
        chk("bp_rsp1_hold_valid", 32'(bus.rsp1_valid_o), 32'd1);
        bus.rsp1_ready_i = 1'b1;
        #1;
        chk("bp_ready1_release", 32'(bus.req1_ready_o), 32'd1);
        tick();
        bus.req1_valid_i = 1'b0;
        chk("bp_rsp1_valid_kept", 32'(bus.rsp1_valid_o), 32'd1);
        chk("bp_rsp1_new_data", bus.rsp1_data_o, 32'h0000_003C);
        tick();
        chk("bp_rsp1_drained", 32'(bus.rsp1_valid_o), 32'd0);
        chk("bp_cnt_final", 32'(bus.contention_cnt_o), 32'd10);

        // Shift ops
        set_req0(1'b1, 3'd7, 32'h8000_0000, 32'd4);
        set_req1(1'b1, 3'd2, 32'd1, 32'd31);
        tick();
        bus.req0_valid_i = 1'b0;
        chk("srai_rsp0", bus.rsp0_data_o, 32'hF800_0000);
        tick();
        bus.req1_valid_i = 1'b0;
        chk("sll_rsp1", bus.rsp1_data_o, 32'h8000_0000);
        chk("shift_cnt", 32'(bus.contention_cnt_o), 32'd11);
        tick();

        // Reset mid-operation with both buffers full and requests pending
        bus.rsp0_ready_i = 1'b0;
        bus.rsp1_ready_i = 1'b0;
        set_req0(1'b1, 3'd3, 32'd1, 32'd1);
        set_req1(1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0000_00AA);
        tick();
        set_req0(1'b1, 3'd3, 32'd20, 32'd22);
        tick();
        #1;
        chk("mid_rsp0_full", 32'(bus.rsp0_valid_o), 32'd1);
        chk("mid_rsp1_full", 32'(bus.rsp1_valid_o), 32'd1);
        chk("mid_rsp1_data", bus.rsp1_data_o, 32'h0000_00AA);
        chk("mid_both_blocked", 32'({bus.req0_ready_o, bus.req1_ready_o}), 32'd0);
        chk("mid_cnt", 32'(bus.contention_cnt_o), 32'd13);
        rst_i = 1'b0;
        #1;
        chk("arst_rsp0_valid", 32'(bus.rsp0_valid_o), 32'd0);
        chk("arst_rsp1_valid", 32'(bus.rsp1_valid_o), 32'd0);
        chk("arst_rsp0_data", bus.rsp0_data_o, 32'd0);
        chk("arst_cnt", 32'(bus.contention_cnt_o), 32'd0);
        chk("arst_no_accept", 32'({bus.req0_ready_o, bus.req1_ready_o}), 32'd0);
        #1;
        rst_i = 1'b1;
        #1;
        chk("post_rst_ready0", 32'(bus.req0_ready_o), 32'd1);
        chk("post_rst_ready1", 32'(bus.req1_ready_o), 32'd0);
        tick();
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        chk("post_rst_rsp0", bus.rsp0_data_o, 32'd42);
        chk("post_rst_cnt", 32'(bus.contention_cnt_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares a single combinational ALU between two requesters (R0, R1) using valid/ready handshakes. Each cycle, at most one requester is granted. Its operands and op code are driven onto the ALU, and the result is captured into that requester's one-entry response buffer. Arbitration is round-robin. A saturating counter reports contention cycles. The block sits between two issue sources (e.g. pipeline EX stage and a multi-cycle helper unit) and the shared ALU instance.

Parameters:
WIDTH, 32, operand/result width
CTRL_W, 3, ALU op code width
CNT_W, 16, contention counter width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
req0_valid_i  in  1  R0 request valid
req0_ready_o  out  1  R0 request accepted this cycle
req0_ctrl_i  in  CTRL_W  R0 ALU op code
req0_data1_i  in  WIDTH  R0 operand 1
req0_data2_i  in  WIDTH  R0 operand 2
rsp0_valid_o  out  1  R0 result valid
rsp0_ready_i  in  1  R0 consumes result
rsp0_data_o  out  WIDTH  R0 result
req1_*/rsp1_*  same set as above, for R1
alu_ctrl_o  out  CTRL_W  op code to shared ALU
alu_data1_o  out  WIDTH  operand 1 to ALU
alu_data2_o  out  WIDTH  operand 2 to ALU
alu_result_i  in  WIDTH  combinational ALU result
contention_cnt_o  out  CNT_W  saturating count of contention cycles

Behaviour:
- Reset (rst_i low, async): rsp0/1_valid_o=0, rsp0/1_data_o=0, priority pointer=R0, contention_cnt_o=0. Pending results are discarded. Requests are not accepted while reset is asserted.
- ALU op encoding: 000 and, 001 xor, 010 sll, 011 add, 100 sub, 101 mul, 110 addi, 111 srai. The arbiter passes ctrl through unmodified.
- Eligibility: elig_k = reqk_valid_i & (!rspk_valid_o | rspk_ready_i).
- Grant (combinational):
  - Only one eligible requester: grant it.
  - Both eligible: grant the requester named by the priority pointer.
  - reqk_ready_o = grant_k. At most one ready is high per cycle.
- ALU drive:
  - While granted: alu_* are the granted requester's ctrl/data1/data2.
  - With no grant: alu_ctrl_o=0, alu_data1_o=0, alu_data2_o=0.
- Capture: on a clock edge with grant_k, rspk_data_o <= alu_result_i and rspk_valid_o <= 1. Latency is 1 cycle from accept to rspk_valid_o.
- Drain: rspk_ready_i & rspk_valid_o with no new grant_k clears rspk_valid_o; data holds its last value.
- Simultaneous drain and accept on the same requester: the new result loads, valid stays 1, no bubble, so sustained throughput is 1 op/cycle.
- Buffer full and not drained: that requester is ineligible and its ready stays low. The other requester may still be granted.
- Priority pointer:
  - After a grant to k, the pointer moves to the other requester.
  - With no grant, the pointer is unchanged.
  - Result: strict alternation under continuous dual load.
- Requester rule: valid, ctrl and operands must hold stable until ready. The arbiter never drops a presented request.
- Contention: increments when req0_valid_i & req1_valid_i & one is denied (both eligible, or one blocked by a full buffer while the other is granted). Saturates at all-ones with no wrap.
- Response channels are independent; results never cross requesters.

Test Plan:
- Single op: after reset, R0 add 5+7 (ctrl 011), rsp0_ready_i=1 → req0_ready_o=1 in cycle 0; rsp0_valid_o=1 with data 12 in cycle 1; alu_* return to 0 in cycle 1; contention_cnt_o=0.
- Dual contention: R0 sub 10-3 and R1 mul 6*7 both valid from cycle 0, both rsp ready=1 → R0 granted cycle 0 (rsp0=7 at cycle 1), R1 granted cycle 1 (rsp1=42 at cycle 2), contention_cnt_o=1.
- Back-to-back fairness: both requesters continuously valid for 8 cycles → grants alternate R0,R1,R0,…, 4 each, one result per cycle, no bubbles.
- Backpressure: R1 xor 0xF0^0xFF with rsp1_ready_i=0 → rsp1 holds 0x0F. A second R1 request (and 0xFF&0x3C) sees req1_ready_o=0 until rsp1_ready_i=1. In that cycle the new request is accepted and rsp1 becomes 0x3C next cycle with valid continuously 1. Meanwhile R0 requests are still granted.
- Shift ops: R0 srai 0x80000000 by 4 → 0xF8000000. R1 sll 1 by 31 → 0x80000000.
- Reset mid-operation: assert rst_i low asynchronously with rsp0_valid_o=1 and R1 pending → all valid outputs drop immediately and contention_cnt_o=0. After release, the first dual request grants R0.
